// File: rtl/demux1in2_16bit.sv
// Registered 1-to-2 demultiplexer with valid/ready flow control and a 2-entry FIFO per destination.
// Optional macro DEMUX_PARITY_EN stores the even parity of each word in bit WIDTH.
module demux1in2_16bit #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             Clock,
    input  logic             Reset_n,
    input  logic [WIDTH-1:0] Hyrja,
    input  logic             Zgjedhja,
    input  logic             Hyrja_valid,
    output logic             Hyrja_ready,
    output logic [WIDTH:0]   Dalja0,
    output logic [WIDTH:0]   Dalja1,
    output logic             Dalja0_valid,
    output logic             Dalja1_valid,
    input  logic             Dalja0_ready,
    input  logic             Dalja1_ready,
    output logic [7:0]       Numri0,
    output logic [7:0]       Numri1
);

    typedef enum logic [1:0] {StEmpty = 2'b00, StOne = 2'b01, StTwo = 2'b10} occ_e;

    logic                  par;
    logic [WIDTH:0]        word;
    logic [1:0]            full;
    logic [1:0]            push;
    logic [1:0]            pop;
    logic [1:0]            out_ready;
    logic [1:0]            out_valid;
    logic [1:0][WIDTH:0]   head_out;
    logic [1:0][7:0]       cnt_out;

`ifdef DEMUX_PARITY_EN
    assign par = ^Hyrja;
`else
    assign par = 1'b0;
`endif

    assign word        = {par, Hyrja};
    assign out_ready   = {Dalja1_ready, Dalja0_ready};
    // Ready looks only at the selected buffer's occupancy, never at Hyrja_valid.
    assign Hyrja_ready = ~full[Zgjedhja];

    for (genvar g = 0; g < 2; g++) begin : g_lane
        occ_e           occ_q, occ_d;
        logic [WIDTH:0] head_q, head_d;
        logic [WIDTH:0] tail_q, tail_d;
        logic [7:0]     cnt_q;

        assign full[g]      = (occ_q == StTwo);
        assign push[g]      = Hyrja_valid & Hyrja_ready & (Zgjedhja == 1'(g));
        assign pop[g]       = (occ_q != StEmpty) & out_ready[g];
        assign out_valid[g] = (occ_q != StEmpty);
        assign head_out[g]  = head_q;
        assign cnt_out[g]   = cnt_q;

        always_comb begin
            occ_d  = occ_q;
            head_d = head_q;
            tail_d = tail_q;
            case (occ_q)
                StEmpty: begin
                    if (push[g]) begin
                        head_d = word;
                        occ_d  = StOne;
                    end
                end
                StOne: begin
                    unique case ({push[g], pop[g]})
                        2'b10: begin
                            tail_d = word;
                            occ_d  = StTwo;
                        end
                        2'b01: occ_d = StEmpty;
                        2'b11: head_d = word;
                        default: ;
                    endcase
                end
                StTwo: begin
                    if (pop[g]) begin
                        head_d = tail_q;
                        occ_d  = StOne;
                    end
                end
                default: occ_d = StEmpty;
            endcase
        end

        always_ff @(posedge Clock or negedge Reset_n) begin
            if (!Reset_n) begin
                occ_q  <= StEmpty;
                head_q <= '0;
                tail_q <= '0;
                cnt_q  <= '0;
            end else begin
                occ_q  <= occ_d;
                head_q <= head_d;
                tail_q <= tail_d;
                if (pop[g]) begin
                    cnt_q <= cnt_q + 8'd1;
                end
            end
        end
    end

    assign Dalja0       = head_out[0];
    assign Dalja1       = head_out[1];
    assign Dalja0_valid = out_valid[0];
    assign Dalja1_valid = out_valid[1];
    assign Numri0       = cnt_out[0];
    assign Numri1       = cnt_out[1];

endmodule

// File: tb/tb_demux1in2_16bit.sv
// Scoreboard bench for demux1in2_16bit: per-destination expected-word queues filled on accept,
// drained and compared by a negedge monitor.
module tb_demux1in2_16bit;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [W-1:0] hyrja = '0;
    logic         sel = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W:0]   d0, d1;
    logic         v0, v1;
    logic         r0 = 1'b1;
    logic         r1 = 1'b1;
    logic [7:0]   n0, n1;

    int checks = 0;
    int errors = 0;

    logic [W:0] q[2][$];
    int         cnt[2];

    always #5 clk = ~clk;

    demux1in2_16bit #(.WIDTH(W)) dut (
        .Clock        (clk),
        .Reset_n      (rst_n),
        .Hyrja        (hyrja),
        .Zgjedhja     (sel),
        .Hyrja_valid  (in_valid),
        .Hyrja_ready  (in_ready),
        .Dalja0       (d0),
        .Dalja1       (d1),
        .Dalja0_valid (v0),
        .Dalja1_valid (v1),
        .Dalja0_ready (r0),
        .Dalja1_ready (r1),
        .Numri0       (n0),
        .Numri1       (n1)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [W:0] model_word(input logic [W-1:0] d);
        logic p;
        p = 1'b0;
`ifdef DEMUX_PARITY_EN
        for (int i = 0; i < W; i++) p = p ^ d[i];
`endif
        return {p, d};
    endfunction

    // Monitor / scoreboard
    always @(negedge clk) begin
        logic [W:0] dv[2];
        logic       vv[2];
        logic       rr[2];
        logic [7:0] nn[2];
        bit         exp_rdy;
        dv[0] = d0; dv[1] = d1;
        vv[0] = v0; vv[1] = v1;
        rr[0] = r0; rr[1] = r1;
        nn[0] = n0; nn[1] = n1;
        if (!rst_n) begin
            for (int d = 0; d < 2; d++) begin
                chk($sformatf("rst_valid%0d", d), 32'(vv[d]), 32'd0);
                chk($sformatf("rst_data%0d", d), 32'(dv[d]), 32'd0);
                chk($sformatf("rst_count%0d", d), 32'(nn[d]), 32'd0);
                q[d].delete();
                cnt[d] = 0;
            end
            chk("rst_in_ready", 32'(in_ready), 32'd1);
        end else begin
            exp_rdy = (q[sel].size() < 2);
            chk("in_ready", 32'(in_ready), 32'(exp_rdy));
            for (int d = 0; d < 2; d++) begin
                chk($sformatf("valid%0d", d), 32'(vv[d]), 32'(q[d].size() != 0));
                chk($sformatf("count%0d", d), 32'(nn[d]), 32'(cnt[d]));
                if (q[d].size() != 0) begin
                    chk($sformatf("data%0d", d), 32'(dv[d]), 32'(q[d][0]));
                    if (rr[d]) begin
                        void'(q[d].pop_front());
                        cnt[d] = (cnt[d] + 1) % 256;
                    end
                end
            end
            if (in_valid && exp_rdy) q[sel].push_back(model_word(hyrja));
        end
    end

    // Offer one word; returns at posedge+1 after it is accepted, valid left high.
    task automatic send(input logic [W-1:0] d, input logic s);
        int n;
        hyrja    = d;
        sel      = s;
        in_valid = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!in_ready && n < 200);
        if (n >= 200) chk("send_timeout", 32'd1, 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n;
        in_valid = 1'b0;
        r0 = 1'b1;
        r1 = 1'b1;
        n = 0;
        while ((q[0].size() != 0 || q[1].size() != 0) && n < 200) begin
            @(posedge clk);
            n++;
        end
        if (n >= 200) chk("drain_timeout", 32'd1, 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("async_valid0", 32'(v0), 32'd0);
        chk("async_valid1", 32'(v1), 32'd0);
        chk("async_count0", 32'(n0), 32'd0);
        chk("async_count1", 32'(n1), 32'd0);
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Fill both destinations to TWO, then reset mid-transfer
        r0 = 1'b0;
        r1 = 1'b0;
        send(16'h1111, 1'b0);
        send(16'h2222, 1'b0);
        send(16'h3333, 1'b1);
        send(16'h4444, 1'b1);
        in_valid = 1'b0;
        @(negedge clk);
        chk("full_valid0", 32'(v0), 32'd1);
        chk("full_valid1", 32'(v1), 32'd1);
        do_reset();
        r0 = 1'b1;
        r1 = 1'b1;
        sel = 1'b0;
        @(negedge clk);
        chk("post_rst_ready_sel0", 32'(in_ready), 32'd1);
        sel = 1'b1;
        #1;
        chk("post_rst_ready_sel1", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;

        // Single routing
        send(16'h1234, 1'b0);
        send(16'hABCD, 1'b1);
        drain();
        chk("single_count0", 32'(n0), 32'd1);
        chk("single_count1", 32'(n1), 32'd1);

        // Backpressure and isolation
        do_reset();
        r0 = 1'b0;
        send(16'hA001, 1'b0);
        send(16'hA002, 1'b0);
        hyrja    = 16'hA003;
        sel      = 1'b0;
        in_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("stall_ready", 32'(in_ready), 32'd0);
            @(posedge clk);
            #1;
        end
        sel = 1'b1;
        #1;
        chk("switch_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        drain();
        chk("bp_count0", 32'(n0), 32'd2);
        chk("bp_count1", 32'(n1), 32'd1);

        // Push and pop together in ONE, consumer ready toggling
        do_reset();
        fork
            begin
                repeat (80) begin
                    @(posedge clk);
                    #1;
                    r1 = ~r1;
                end
            end
            begin
                for (int i = 1; i <= 16; i++) send(16'(i), 1'b1);
                in_valid = 1'b0;
            end
        join
        drain();
        chk("stream_count1", 32'(n1), 32'd16);

        // Counter wrap
        do_reset();
        for (int i = 0; i < 257; i++) send(16'(i * 7 + 3), 1'b0);
        drain();
        chk("wrap_count0", 32'(n0), 32'd1);

        // Parity samples (bit W checked by the scoreboard in either build)
        send(16'h0007, 1'b0);
        send(16'h0003, 1'b0);
        drain();

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            in_valid = ($urandom_range(3) != 0);
            hyrja    = 16'($urandom);
            sel      = 1'($urandom);
            r0       = ($urandom_range(2) != 0);
            r1       = 1'($urandom);
            @(posedge clk);
            #1;
        end
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/demux1in2_16bit.md
# demux1in2_16bit

Registered 1-to-2 demultiplexer with valid/ready flow control, the routing counterpart of the datapath's 2-input 16-bit selector. A 16-bit word offered on `Hyrja` is steered by `Zgjedhja` to one of two destinations, `Dalja0` or `Dalja1`. Each destination has its own 2-entry buffer, so a stalled destination never blocks the other. The block sits between the CPU's result bus and two consumers, for example the register-file write port and the memory write port.

## Interface
- `WIDTH`, default 16: data word width.
- `Clock`  input  1  rising-edge clock.
- `Reset_n`  input  1  reset, asynchronous assert, active-low.
- `Hyrja`  input  WIDTH  data word offered by the producer.
- `Zgjedhja`  input  1  destination select: 0 routes to `Dalja0`, 1 routes to `Dalja1`.
- `Hyrja_valid`  input  1  the producer is offering a word.
- `Hyrja_ready`  output  1  the block accepts the word this cycle.
- `Dalja0`, `Dalja1`  output  WIDTH+1  head word of each destination buffer; bit WIDTH is the parity field.
- `Dalja0_valid`, `Dalja1_valid`  output  1  the head word is valid.
- `Dalja0_ready`, `Dalja1_ready`  input  1  the consumer accepts the head word.
- `Numri0`, `Numri1`  output  8  wrapping count of words delivered on each destination.

## Operation
- Accept condition: accept = `Hyrja_valid` & `Hyrja_ready`.
  - `Hyrja_ready` = buffer[`Zgjedhja`] not full.
  - `Hyrja_ready` is combinational from `Zgjedhja` and buffer occupancy only. It never depends on `Hyrja_valid`.
- Delivery condition: popN = `DaljaN_valid` & `DaljaN_ready`.
- Each buffer is a 2-entry FIFO with occupancy states EMPTY, ONE and TWO.
  - EMPTY: a push moves to ONE.
  - ONE: push only moves to TWO; pop only moves to EMPTY; push and pop together stay in ONE, and the pushed word becomes the head.
  - TWO: no push is possible (full); a pop moves to ONE.
  - An illegal state returns to EMPTY.
- `DaljaN_valid` = occupancy ≠ EMPTY.
- `DaljaN` = head entry. It holds stable while valid and not ready.
- Per-destination ordering is preserved. There is no ordering guarantee between the two destinations.
- `NumriN` increments by 1 on each popN and wraps from 255 to 0.
- A word offered to a full destination is not accepted. The producer holds it, and no word is dropped or duplicated.
- `Zgjedhja` may change while `Hyrja_valid` is high and not accepted. The word is routed according to `Zgjedhja` in the accept cycle.
- A destination's data width is WIDTH+1. Bits [WIDTH-1:0] carry `Hyrja` unmodified. Bit WIDTH is set by the Configuration section.

## Timing
- Reset values while `Reset_n` = 0:
  - both buffers EMPTY;
  - `Dalja0_valid` = `Dalja1_valid` = 0;
  - `Dalja0` = `Dalja1` = 0;
  - `Numri0` = `Numri1` = 0;
  - `Hyrja_ready` = 1.
- Reset asserted mid-transfer discards all buffered words immediately, asynchronously. Release is synchronous to the next `Clock` edge.
- Latency: a word accepted at edge k appears on `DaljaN` with valid asserted after edge k, one cycle.
- Throughput: with the consumer ready every cycle, one word per cycle per destination is sustained indefinitely.
- A destination stalled for 2 pushes reaches TWO and drops ready for that select only. The other destination keeps accepting.
- After a full stall, `Hyrja_ready` for that select returns 1 in the cycle after the first pop (combinational from occupancy).

## Configuration
- `DEMUX_PARITY_EN` defined: bit WIDTH of each stored word is the even parity (XOR reduction) of `Hyrja`, computed at accept time and held with the word.
- `DEMUX_PARITY_EN` undefined: bit WIDTH is constant 0. No parity logic is synthesized, and all other behaviour is identical.

## Test plan
- Reset check: assert `Reset_n`=0 with both buffers at TWO. Required:
  - valids drop at once;
  - `Numri0`=`Numri1`=0;
  - after release, `Hyrja_ready`=1 for both selects.
- Single routing: send 0x1234 with select 0, then 0xABCD with select 1, both consumers ready. Required:
  - `Dalja0`[15:0]=0x1234 one cycle after its accept;
  - `Dalja1`[15:0]=0xABCD one cycle after its accept;
  - `Numri0`=`Numri1`=1.
- Backpressure and isolation: hold `Dalja0_ready`=0 and send 3 words to destination 0. Required:
  - the third word is not accepted while `Hyrja_ready`=0;
  - switching select to 1 is accepted immediately;
  - releasing `Dalja0_ready` delivers the words in order with no loss.
- Simultaneous push and pop in ONE: stream 0x0001..0x0010 to destination 1 with ready toggling every cycle. Required: all 16 words delivered in order and `Numri1`=16.
- Counter wrap: deliver 257 words on destination 0. Required: `Numri0`=1.
- Parity: with `DEMUX_PARITY_EN`, send 0x0007. Required: `Dalja0`[16]=1; send 0x0003: `Dalja0`[16]=0. Without the macro, bit 16 is always 0.
